ame_pri_8b: RTL and testbench

AME_PRI_8B -- requirements
Module: ame_pri_8b

---
 rtl/ame_pri_8b.sv | 49 ++++
 tb/tb_ame_pri_8b.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ame_pri_8b.sv
// ame_pri_8b: cascadable 8-bit priority encoder slice (bit 7 highest), registered outputs.
// Define AME_PRI_8B_COMB_EN to drop the output register and make the outputs combinational.
module ame_pri_8b (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       carry_i,
    input  logic [7:0] data_i,
    output logic       carry_o,
    output logic [7:0] data_o
);
    logic [3:0] any2;
    logic [7:0] gnt2;
    logic [1:0] any4;
    logic [7:0] gnt4;
    logic [7:0] gnt8;
    logic       any8;
    logic [7:0] data_nxt;
    logic       carry_nxt;

    // Tree: pairs pick their upper bit, then each level masks its lower half if the upper half hit.
    genvar i;
    for (i = 0; i < 4; i++) begin : g_pair
        assign any2[i]         = |data_i[2*i +: 2];
        assign gnt2[2*i +: 2]  = {data_i[2*i+1], data_i[2*i] & ~data_i[2*i+1]};
    end
    for (i = 0; i < 2; i++) begin : g_quad
        assign any4[i]         = any2[2*i+1] | any2[2*i];
        assign gnt4[4*i +: 4]  = {gnt2[4*i+2 +: 2], any2[2*i+1] ? 2'b00 : gnt2[4*i +: 2]};
    end
    assign gnt8      = {gnt4[7:4], any4[1] ? 4'h0 : gnt4[3:0]};
    assign any8      = any4[1] | any4[0];
    assign data_nxt  = carry_i ? gnt8 : 8'h00;
    assign carry_nxt = carry_i & ~any8;

`ifdef AME_PRI_8B_COMB_EN
    assign data_o  = rst_n_i ? data_nxt : 8'h00;
    assign carry_o = rst_n_i & carry_nxt;
`else
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o  <= 8'h00;
            carry_o <= 1'b0;
        end else begin
            data_o  <= data_nxt;
            carry_o <= carry_nxt;
        end
    end
`endif
endmodule

// File: tb/tb_ame_pri_8b.sv
// tb_ame_pri_8b: table-driven and exhaustive checks of ame_pri_8b against a linear-scan model.
module tb_ame_pri_8b;
    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       carry_i = 1'b1;
    logic [7:0] data_i = 8'hff;
    logic       carry_o;
    logic [7:0] data_o;

    typedef struct {
        logic       c;
        logic [7:0] d;
        logic [7:0] ed;
        logic       ec;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       c;
    } exp_t;

    exp_t q[$];
    vec_t tbl[18];
    int   applied = 0;
    int   errs = 0;

    ame_pri_8b dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .carry_i (carry_i),
        .data_i  (data_i),
        .carry_o (carry_o),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic exp_t model(input logic c, input logic [7:0] d);
        exp_t e;
        logic found;
        e.d   = 8'h00;
        e.c   = c && (d == 8'h00);
        found = 1'b0;
        for (int b = 7; b >= 0; b--)
            if (c && !found && d[b]) begin
                e.d[b] = 1'b1;
                found  = 1'b1;
            end
        return e;
    endfunction

    function automatic exp_t mk(input logic [7:0] d, input logic c);
        exp_t e;
        e.d = d;
        e.c = c;
        return e;
    endfunction

    task automatic check(input string name, input exp_t e);
        applied++;
        if (data_o !== e.d || carry_o !== e.c) begin
            errs++;
            $display("FAIL %s: data_o=%h carry_o=%b, expected data_o=%h carry_o=%b",
                     name, data_o, carry_o, e.d, e.c);
        end
    endtask

    // Latency 1 in the registered build, 0 in the combinational build.
    task automatic settle();
`ifdef AME_PRI_8B_COMB_EN
        #1;
`else
        @(posedge clk_i);
        #1;
`endif
    endtask

    task automatic drive(input string name, input logic c, input logic [7:0] d, input exp_t e);
        exp_t x;
        carry_i = c;
        data_i  = d;
        q.push_back(e);
        settle();
        if (q.size() == 0) begin
            errs++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            x = q.pop_front();
            check(name, x);
        end
    endtask

    initial begin
        logic [7:0] din[8];
        logic [7:0] dex[8];
        din = '{8'h17, 8'h37, 8'hcd, 8'haa, 8'h0a, 8'h1f, 8'h3d, 8'hff};
        dex = '{8'h10, 8'h20, 8'h80, 8'h80, 8'h08, 8'h10, 8'h20, 8'h80};
        for (int k = 0; k < 8; k++) begin
            tbl[k]   = '{1'b1, din[k], dex[k], 1'b0};
            tbl[k+8] = '{1'b0, din[k], 8'h00, 1'b0};
        end
        tbl[16] = '{1'b1, 8'h00, 8'h00, 1'b1};
        tbl[17] = '{1'b1, 8'h01, 8'h01, 1'b0};

        #1;
        check("reset_t0", mk(8'h00, 1'b0));
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_hold", mk(8'h00, 1'b0));

        @(negedge clk_i);
        rst_n_i = 1'b1;
        drive("reset_release", 1'b1, 8'hff, mk(8'h80, 1'b0));

        for (int k = 0; k < 18; k++)
            drive($sformatf("tbl%0d_c%0b_d%h", k, tbl[k].c, tbl[k].d),
                  tbl[k].c, tbl[k].d, mk(tbl[k].ed, tbl[k].ec));

        for (int c = 0; c < 2; c++)
            for (int d = 0; d < 256; d++)
                drive($sformatf("exh_c%0d_d%02h", c, d), c[0], d[7:0], model(c[0], d[7:0]));

        drive("pre_async", 1'b1, 8'h40, mk(8'h40, 1'b0));
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async_reset", mk(8'h00, 1'b0));
        @(posedge clk_i);
        #1;
        check("reset_held_edge", mk(8'h00, 1'b0));
        @(negedge clk_i);
        rst_n_i = 1'b1;
        drive("recover", 1'b1, 8'h03, mk(8'h02, 1'b0));
        drive("recover_zero", 1'b1, 8'h00, mk(8'h00, 1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end
endmodule
